// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: MCycleOp values,
// FSM state codes and small op-decode helpers.
// Latency: n/a (constants only). Backpressure: n/a.
// Imported by the unit and by the decoder that produces MCycleOpD.
package mcycle_unit_pkg;

  // MCycleOp encodings: bit 1 selects divide, bit 0 selects unsigned
  localparam logic [1:0] MC_MUL_S = 2'b00;
  localparam logic [1:0] MC_MUL_U = 2'b01;
  localparam logic [1:0] MC_DIV_S = 2'b10;
  localparam logic [1:0] MC_DIV_U = 2'b11;

  // FSM state codes
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MC_DIV_S) || (op == MC_DIV_U);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MC_MUL_S) || (op == MC_DIV_S);
  endfunction

endpackage

// File: rtl/mcycle_unit_if.sv
// Execute-stage port bundle of the multi-cycle unit: request, operands, results, stall.
// Latency: n/a (wires only). Backpressure: Busy is the stall back to the F/D/E registers.
// Ports: Start, MCycleOp, Operand1, Operand2 (E stage -> unit); Result1, Result2, Busy (unit -> E stage).
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  // master = execute stage, slave = the multi-cycle unit
  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy
  );

endinterface

// File: rtl/mcycle_unit_divstep.sv
// One restoring-division step: shift a dividend bit into the remainder, try to subtract the divisor.
// Latency: combinational. Backpressure: none.
// Ports: rem_i (partial remainder, < dvsr_i), bit_i (next dividend bit), dvsr_i -> rem_o, qbit_o.
module mcycle_unit_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < dvsr_i keeps shifted below 2*dvsr_i, so bit WIDTH of the
  // difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvsr_i};
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide for the execute stage: shift-add multiply, restoring divide, one bit per cycle.
// Latency: WIDTH+1 Busy cycles per op (request + WIDTH compute); divide-by-zero/overflow take 1 Busy cycle.
// Backpressure: combinational Busy stalls F/D/E from the cycle Start appears until results are ready.
// Ports: CLK, RESETn (sync, active-low), bus (slave modport: Start/MCycleOp/Operand1/Operand2 in,
//        Result1/Result2/Busy out). Result1 = low product / quotient, Result2 = high product / remainder.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RESETn,
  mcycle_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  // state
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;         // product / quotient sign
  logic               neg_rem_q, neg_rem_d; // remainder follows the dividend
  logic [WIDTH-1:0]   mcand_q, mcand_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;         // mul: {hi, multiplier}; div: {rem, dividend/quot}
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  // datapath
  logic               in_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;

  mcycle_unit_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem_i  (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i  (acc_q[WIDTH-1]),
    .dvsr_i (mcand_q),
    .rem_o  (div_rem),
    .qbit_o (div_qbit)
  );

  // Magnitudes of the live operands; only signed ops fold the sign away.
  always_comb begin
    in_signed = op_is_signed(bus.MCycleOp);
    a_neg     = in_signed & bus.Operand1[WIDTH-1];
    b_neg     = in_signed & bus.Operand2[WIDTH-1];
    abs_a     = a_neg ? -bus.Operand1 : bus.Operand1;
    abs_b     = b_neg ? -bus.Operand2 : bus.Operand2;
  end

  // One iteration of each algorithm from the registered accumulator.
  always_comb begin
    // Add into the high half with a carry bit, then shift the whole thing right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_mul  = {mul_sum, acc_q[WIDTH-1:1]};
    // Dividend bits leave the top of the low half while quotient bits enter at the bottom.
    acc_div  = {div_rem, acc_q[WIDTH-2:0], div_qbit};
    acc_nxt  = op_is_div(op_q) ? acc_div : acc_mul;
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    result1_d = result1_q;
    result2_d = result2_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          op_d  = bus.MCycleOp;
          cnt_d = '0;
          if (op_is_div(bus.MCycleOp) && (bus.Operand2 == '0)) begin
            state_d   = ST_DONE;
            result1_d = ONES;
            result2_d = bus.Operand1;
          end else if ((bus.MCycleOp == MC_DIV_S) && (bus.Operand1 == MIN_INT) &&
                       (bus.Operand2 == ONES)) begin
            // The true quotient +2^(WIDTH-1) does not fit; saturate to MIN_INT.
            state_d   = ST_DONE;
            result1_d = MIN_INT;
            result2_d = '0;
          end else begin
            state_d   = ST_COMPUTE;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (op_is_div(bus.MCycleOp)) begin
              mcand_d = abs_b;
              acc_d   = {{WIDTH{1'b0}}, abs_a};
            end else begin
              mcand_d = abs_a;
              acc_d   = {{WIDTH{1'b0}}, abs_b};
            end
          end
        end
      end

      ST_COMPUTE: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          // Sign correction is folded into the last iteration's edge.
          if (op_is_div(op_q)) begin
            result1_d = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
            result2_d = neg_rem_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
          end else begin
            result1_d = prod_fix[WIDTH-1:0];
            result2_d = prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end

      // The E register still shows the old Start here, so it must not launch a new op.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  // Stall starts in the same cycle Start first appears; reset forces it low.
  assign bus.Busy    = RESETn & ((state_q == ST_COMPUTE) | ((state_q == ST_IDLE) & bus.Start));
  assign bus.Result1 = result1_q;
  assign bus.Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
module tb_mcycle_unit;
  import mcycle_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  mcycle_unit_if #(.WIDTH(32)) bus ();

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request starting at posedge+1, counts Busy cycles sampled at
  // posedge+2, and returns in the first non-busy cycle (DONE). Operands and op
  // are scrambled after the request edge to expose any late sampling.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int cycles);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    cycles = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!bus.Busy) break;
      cycles++;
      @(posedge clk); #1;
      if (!hold) bus.Start = 1'b0;
      bus.Operand1 = ~a ^ 32'h5a5a_0f0f;
      bus.Operand2 = b + 32'd3;
      bus.MCycleOp = ~op;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Start = 1'b1;
    bus.MCycleOp = MC_MUL_U;
    bus.Operand1 = 32'd5;
    bus.Operand2 = 32'd6;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.Busy); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'h0) $display("FAIL reset_r1: got %h want 0", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'h0) $display("FAIL reset_r2: got %h want 0", bus.Result2); else n_pass++;
    bus.Start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.Busy); else n_pass++;
  endtask

  task automatic test_unsigned_mul();
    int cyc;
    @(posedge clk); #1;
    run_op(MC_MUL_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL umul_busy: got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'h0000_0001) $display("FAIL umul_r1: got %h want 00000001", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'hFFFF_FFFE) $display("FAIL umul_r2: got %h want fffffffe", bus.Result2); else n_pass++;
  endtask

  task automatic test_signed_mul();
    int cyc;
    @(posedge clk); #1;
    run_op(MC_MUL_S, 32'hFFFF_FFF9, 32'd6, 1'b0, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL smul_busy: got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'hFFFF_FFD6) $display("FAIL smul_r1: got %h want ffffffd6", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'hFFFF_FFFF) $display("FAIL smul_r2: got %h want ffffffff", bus.Result2); else n_pass++;
  endtask

  task automatic test_div();
    int cyc;
    @(posedge clk); #1;
    run_op(MC_DIV_S, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
    n_checks++;
    if (bus.Result1 !== 32'hFFFF_FFFD) $display("FAIL sdiv_q: got %h want fffffffd", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'hFFFF_FFFF) $display("FAIL sdiv_r: got %h want ffffffff", bus.Result2); else n_pass++;
    @(posedge clk); #1;
    run_op(MC_DIV_U, 32'd100, 32'd7, 1'b0, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL udiv_busy: got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'd14) $display("FAIL udiv_q: got %0d want 14", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'd2) $display("FAIL udiv_r: got %0d want 2", bus.Result2); else n_pass++;
  endtask

  task automatic test_div_special();
    int cyc;
    @(posedge clk); #1;
    run_op(MC_DIV_U, 32'h0000_1234, 32'h0, 1'b0, cyc);
    n_checks++;
    if (cyc !== 1) $display("FAIL dz_busy: got %0d want 1", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'hFFFF_FFFF) $display("FAIL dz_q: got %h want ffffffff", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'h0000_1234) $display("FAIL dz_r: got %h want 00001234", bus.Result2); else n_pass++;
    @(posedge clk); #1;
    run_op(MC_DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    n_checks++;
    if (cyc !== 1) $display("FAIL ovf_busy: got %0d want 1", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'h8000_0000) $display("FAIL ovf_q: got %h want 80000000", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'h0) $display("FAIL ovf_r: got %h want 0", bus.Result2); else n_pass++;
  endtask

  task automatic test_start_held();
    int cyc;
    @(posedge clk); #1;
    run_op(MC_MUL_U, 32'd9, 32'd11, 1'b1, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL held_busy: got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL held_done_busy: got %b want 0", bus.Busy); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'd99) $display("FAIL held_r1: got %0d want 99", bus.Result1); else n_pass++;
    bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL held_no_rerun: got %b want 0", bus.Busy); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'd99) $display("FAIL held_keep_r1: got %0d want 99", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'd0) $display("FAIL held_keep_r2: got %0d want 0", bus.Result2); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(posedge clk); #1;
    run_op(MC_MUL_U, 32'd3, 32'd5, 1'b1, cyc);
    n_checks++;
    if (bus.Result1 !== 32'd15) $display("FAIL b2b_first_r1: got %0d want 15", bus.Result1); else n_pass++;
    @(posedge clk); #1;
    run_op(MC_DIV_S, 32'hFFFF_FF9C, 32'd7, 1'b0, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL b2b_busy: got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'hFFFF_FFF2) $display("FAIL b2b_q: got %h want fffffff2", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'hFFFF_FFFE) $display("FAIL b2b_r: got %h want fffffffe", bus.Result2); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(posedge clk); #1;
    bus.Start    = 1'b1;
    bus.MCycleOp = MC_MUL_U;
    bus.Operand1 = 32'd123;
    bus.Operand2 = 32'd456;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (bus.Busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus.Busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL mid_busy_in_reset: got %b want 0", bus.Busy); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", bus.Busy); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'h0) $display("FAIL mid_r1: got %h want 0", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'h0) $display("FAIL mid_r2: got %h want 0", bus.Result2); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL mid_idle: got %b want 0", bus.Busy); else n_pass++;
    run_op(MC_DIV_U, 32'd100, 32'd7, 1'b0, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL mid_next_busy: got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (bus.Result1 !== 32'd14) $display("FAIL mid_next_q: got %0d want 14", bus.Result1); else n_pass++;
    n_checks++;
    if (bus.Result2 !== 32'd2) $display("FAIL mid_next_r: got %0d want 2", bus.Result2); else n_pass++;
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    rst_n        = 1'b0;
    test_reset();
    test_unsigned_mul();
    test_signed_mul();
    test_div();
    test_div_special();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
